wshb_prio_arbiter: RTL and testbench

- Two-requester Wishbone arbiter that shares the single SDRAM Wishbone master port between the VGA frame fetcher (port 0, high priority) and the pattern generator (port 1, low priority).
- Grant is held for a whole Wishbone cycle (cyc high), so pipelined bursts are never split.
- A bounded-wait counter guarantees the low-priority port is serviced despite continuous VGA traffic.
- Sits between the two internal buses and the hw_support SDRAM slave, all in the sys_clk domain.

---
 rtl/wshb_arb_pkg.sv | 31 +++
 rtl/wshb_prio_arbiter_wait_ctr.sv | 31 +++
 rtl/wshb_prio_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wshb_prio_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-port Wishbone priority arbiter.
// Optional statistics counters are enabled with ARB_STATS_EN.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int WAIT_W = 16;
    localparam int STAT_W = 32;

    function automatic logic [1:0] onehot_gnt(
        input arb_state_t st
    );
        logic [1:0] g;
        g = 2'b00;
        case (st)
            OWN0:    g = 2'b01;
            OWN1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wshb_prio_arbiter_wait_ctr.sv
// Saturating wait counter for the low-priority port.
// starve flags that port 1 has waited MAX_WAIT cycles.
module arb_wait_ctr
    import wshb_arb_pkg::*;
#(
    parameter int MAX_WAIT = 64
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starve = (wait_cnt == LIMIT);

endmodule

// File: rtl/wshb_prio_arbiter.sv
// Two-port Wishbone arbiter, port 0 high priority, grant held per cycle.
// Define ARB_STATS_EN to add grant/starvation statistics outputs.
module wshb_prio_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADR_W      = 32,
    parameter int DATA_BYTES = 4,
    parameter int MAX_WAIT   = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,

    input  logic                    s0_cyc,
    input  logic                    s0_stb,
    input  logic                    s0_we,
    input  logic [ADR_W-1:0]        s0_adr,
    input  logic [8*DATA_BYTES-1:0] s0_dat_ms,
    input  logic [DATA_BYTES-1:0]   s0_sel,
    input  logic [2:0]              s0_cti,
    input  logic [1:0]              s0_bte,
    output logic [8*DATA_BYTES-1:0] s0_dat_sm,
    output logic                    s0_ack,
    output logic                    s0_err,
    output logic                    s0_rty,

    input  logic                    s1_cyc,
    input  logic                    s1_stb,
    input  logic                    s1_we,
    input  logic [ADR_W-1:0]        s1_adr,
    input  logic [8*DATA_BYTES-1:0] s1_dat_ms,
    input  logic [DATA_BYTES-1:0]   s1_sel,
    input  logic [2:0]              s1_cti,
    input  logic [1:0]              s1_bte,
    output logic [8*DATA_BYTES-1:0] s1_dat_sm,
    output logic                    s1_ack,
    output logic                    s1_err,
    output logic                    s1_rty,

    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [ADR_W-1:0]        m_adr,
    output logic [8*DATA_BYTES-1:0] m_dat_ms,
    output logic [DATA_BYTES-1:0]   m_sel,
    output logic [2:0]              m_cti,
    output logic [1:0]              m_bte,
    input  logic [8*DATA_BYTES-1:0] m_dat_sm,
    input  logic                    m_ack,
    input  logic                    m_err,
    input  logic                    m_rty,

`ifdef ARB_STATS_EN
    output logic [STAT_W-1:0]       stat_gnt0,
    output logic [STAT_W-1:0]       stat_gnt1,
    output logic [STAT_W-1:0]       stat_starve,
`endif
    output logic [1:0]              gnt
);

    arb_state_t state;
    logic       starve;
    logic       take0;
    logic       take1;
    logic       drop;
    logic       forced;

    // Release of the owner re-arbitrates in the same cycle, so a
    // waiting port is granted without an intervening IDLE cycle.
    assign take0 =
        ((state == IDLE) && s0_cyc && !(s1_cyc && starve)) ||
        ((state == OWN1) && !s1_cyc && s0_cyc);

    assign take1 =
        ((state == IDLE) && s1_cyc && (!s0_cyc || starve)) ||
        ((state == OWN0) && !s0_cyc && s1_cyc);

    assign drop =
        ((state == OWN0) && !s0_cyc && !s1_cyc) ||
        ((state == OWN1) && !s1_cyc && !s0_cyc);

    assign forced =
        (state == IDLE) && s0_cyc && s1_cyc && starve;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            gnt   <= 2'b00;
        end else if (take0) begin
            state <= OWN0;
            gnt   <= onehot_gnt(OWN0);
        end else if (take1) begin
            state <= OWN1;
            gnt   <= onehot_gnt(OWN1);
        end else if (drop) begin
            state <= IDLE;
            gnt   <= onehot_gnt(IDLE);
        end
    end

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .inc     (s1_cyc && (state != OWN1)),
        .clr     (take1),
        .starve  (starve)
    );

    always_comb begin
        m_cyc     = 1'b0;
        m_stb     = 1'b0;
        m_we      = 1'b0;
        m_adr     = '0;
        m_dat_ms  = '0;
        m_sel     = '0;
        m_cti     = CTI_CLASSIC;
        m_bte     = 2'b00;
        s0_dat_sm = '0;
        s0_ack    = 1'b0;
        s0_err    = 1'b0;
        s0_rty    = 1'b0;
        s1_dat_sm = '0;
        s1_ack    = 1'b0;
        s1_err    = 1'b0;
        s1_rty    = 1'b0;
        unique case (1'b1)
            gnt[0]: begin
                m_cyc     = s0_cyc;
                m_stb     = s0_stb;
                m_we      = s0_we;
                m_adr     = s0_adr;
                m_dat_ms  = s0_dat_ms;
                m_sel     = s0_sel;
                m_cti     = s0_cti;
                m_bte     = s0_bte;
                s0_dat_sm = m_dat_sm;
                s0_ack    = m_ack;
                s0_err    = m_err;
                s0_rty    = m_rty;
            end
            gnt[1]: begin
                m_cyc     = s1_cyc;
                m_stb     = s1_stb;
                m_we      = s1_we;
                m_adr     = s1_adr;
                m_dat_ms  = s1_dat_ms;
                m_sel     = s1_sel;
                m_cti     = s1_cti;
                m_bte     = s1_bte;
                s1_dat_sm = m_dat_sm;
                s1_ack    = m_ack;
                s1_err    = m_err;
                s1_rty    = m_rty;
            end
            default: ;
        endcase
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stat_gnt0   <= '0;
            stat_gnt1   <= '0;
            stat_starve <= '0;
        end else begin
            if (take0 && (stat_gnt0 != '1))
                stat_gnt0 <= stat_gnt0 + 1'b1;
            if (take1 && (stat_gnt1 != '1))
                stat_gnt1 <= stat_gnt1 + 1'b1;
            if (forced && (stat_starve != '1))
                stat_starve <= stat_starve + 1'b1;
        end
    end
`else
    logic unused_forced;
    assign unused_forced = forced;
`endif

endmodule

// File: tb/tb_wshb_prio_arbiter.sv
// Directed bench for wshb_prio_arbiter (MAX_WAIT=16).
// Checks stats outputs too when built with ARB_STATS_EN.
module tb_wshb_prio_arbiter;
    import wshb_arb_pkg::*;

    localparam int AW = 32;
    localparam int DB = 4;
    localparam int DW = 8 * DB;

    localparam logic [DW-1:0] D0  = 32'hD0D0_0000;
    localparam logic [DW-1:0] D1  = 32'hD1D1_0000;
    localparam logic [DW-1:0] DSM = 32'hCAFE_0001;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          s0_cyc, s0_stb, s0_we;
    logic [AW-1:0] s0_adr;
    logic [DW-1:0] s0_dat_ms, s0_dat_sm;
    logic [DB-1:0] s0_sel;
    logic [2:0]    s0_cti;
    logic [1:0]    s0_bte;
    logic          s0_ack, s0_err, s0_rty;
    logic          s1_cyc, s1_stb, s1_we;
    logic [AW-1:0] s1_adr;
    logic [DW-1:0] s1_dat_ms, s1_dat_sm;
    logic [DB-1:0] s1_sel;
    logic [2:0]    s1_cti;
    logic [1:0]    s1_bte;
    logic          s1_ack, s1_err, s1_rty;
    logic          m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat_ms, m_dat_sm;
    logic [DB-1:0] m_sel;
    logic [2:0]    m_cti;
    logic [1:0]    m_bte;
    logic          m_ack, m_err, m_rty;
    logic [1:0]    gnt;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_gnt0, stat_gnt1, stat_starve;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    wshb_prio_arbiter #(
        .ADR_W      (AW),
        .DATA_BYTES (DB),
        .MAX_WAIT   (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .s0_cyc    (s0_cyc),
        .s0_stb    (s0_stb),
        .s0_we     (s0_we),
        .s0_adr    (s0_adr),
        .s0_dat_ms (s0_dat_ms),
        .s0_sel    (s0_sel),
        .s0_cti    (s0_cti),
        .s0_bte    (s0_bte),
        .s0_dat_sm (s0_dat_sm),
        .s0_ack    (s0_ack),
        .s0_err    (s0_err),
        .s0_rty    (s0_rty),
        .s1_cyc    (s1_cyc),
        .s1_stb    (s1_stb),
        .s1_we     (s1_we),
        .s1_adr    (s1_adr),
        .s1_dat_ms (s1_dat_ms),
        .s1_sel    (s1_sel),
        .s1_cti    (s1_cti),
        .s1_bte    (s1_bte),
        .s1_dat_sm (s1_dat_sm),
        .s1_ack    (s1_ack),
        .s1_err    (s1_err),
        .s1_rty    (s1_rty),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_adr     (m_adr),
        .m_dat_ms  (m_dat_ms),
        .m_sel     (m_sel),
        .m_cti     (m_cti),
        .m_bte     (m_bte),
        .m_dat_sm  (m_dat_sm),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .m_rty     (m_rty),
`ifdef ARB_STATS_EN
        .stat_gnt0   (stat_gnt0),
        .stat_gnt1   (stat_gnt1),
        .stat_starve (stat_starve),
`endif
        .gnt       (gnt)
    );

    typedef struct {
        logic          c0;
        logic          c1;
        logic          ack;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    e_gnt;
        logic          e_cyc;
        logic [AW-1:0] e_adr;
        logic          e_ack0;
        logic          e_ack1;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic drive(input logic c0, input logic c1,
                         input logic ack);
        @(negedge sys_clk);
        s0_cyc = c0;
        s0_stb = c0;
        s1_cyc = c1;
        s1_stb = c1;
        m_ack  = ack;
        m_err  = ack;
        m_rty  = ack;
        #1;
    endtask

    task automatic chk_bus(input string nm,
                           input logic [1:0] eg,
                           input logic ec,
                           input logic [AW-1:0] ea,
                           input logic ek0,
                           input logic ek1);
        logic [DW-1:0] ed;
        logic [DB-1:0] es;
        ed = (eg == 2'b01) ? D0 : (eg == 2'b10) ? D1 : '0;
        es = (eg == 2'b01) ? 4'h3 : (eg == 2'b10) ? 4'hC : 4'h0;
        chk({nm, ".gnt"}, 64'(gnt), 64'(eg));
        chk({nm, ".cyc"}, 64'({m_cyc, m_stb}), 64'({ec, ec}));
        chk({nm, ".adr"}, 64'(m_adr), 64'(ea));
        chk({nm, ".wdat"}, {m_dat_ms, 28'd0, m_sel},
            {ed, 28'd0, es});
        chk({nm, ".resp0"}, 64'({s0_ack, s0_err, s0_rty}),
            64'({ek0, ek0, ek0}));
        chk({nm, ".resp1"}, 64'({s1_ack, s1_err, s1_rty}),
            64'({ek1, ek1, ek1}));
        chk({nm, ".rdat"}, {s0_dat_sm, s1_dat_sm},
            {eg[0] ? DSM : 32'd0, eg[1] ? DSM : 32'd0});
    endtask

    initial begin
        sys_rst   = 1'b1;
        s0_we     = 1'b1;
        s1_we     = 1'b0;
        s0_dat_ms = D0;
        s1_dat_ms = D1;
        s0_sel    = 4'h3;
        s1_sel    = 4'hC;
        s0_cti    = CTI_CLASSIC;
        s1_cti    = CTI_CLASSIC;
        s0_bte    = 2'b00;
        s1_bte    = 2'b00;
        s0_adr    = 32'h100;
        s1_adr    = 32'h0;
        m_dat_sm  = DSM;

        //          c0  c1  ack a0      a1      gnt    cyc adr     k0 k1
        tbl[0]  = '{1, 0, 0, 32'h100, 32'h0, 2'b00, 0, 32'h0,   0, 0};
        tbl[1]  = '{1, 0, 1, 32'h100, 32'h0, 2'b01, 1, 32'h100, 1, 0};
        tbl[2]  = '{0, 0, 0, 32'h100, 32'h0, 2'b01, 0, 32'h100, 0, 0};
        tbl[3]  = '{0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0,   0, 0};
        tbl[4]  = '{1, 1, 0, 32'h200, 32'h300, 2'b00, 0, 32'h0, 0, 0};
        tbl[5]  = '{1, 1, 1, 32'h200, 32'h300, 2'b01, 1, 32'h200, 1, 0};
        tbl[6]  = '{0, 1, 1, 32'h200, 32'h300, 2'b01, 0, 32'h200, 1, 0};
        tbl[7]  = '{0, 1, 1, 32'h200, 32'h300, 2'b10, 1, 32'h300, 0, 1};
        tbl[8]  = '{1, 1, 0, 32'h400, 32'h300, 2'b10, 1, 32'h300, 0, 0};
        tbl[9]  = '{1, 0, 0, 32'h400, 32'h300, 2'b10, 0, 32'h300, 0, 0};
        tbl[10] = '{1, 0, 1, 32'h400, 32'h300, 2'b01, 1, 32'h400, 1, 0};
        tbl[11] = '{1, 1, 0, 32'h400, 32'h300, 2'b01, 1, 32'h400, 0, 0};
        tbl[12] = '{1, 0, 0, 32'h400, 32'h300, 2'b01, 1, 32'h400, 0, 0};
        tbl[13] = '{0, 0, 0, 32'h400, 32'h300, 2'b01, 0, 32'h400, 0, 0};
        tbl[14] = '{0, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0,   0, 0};

        // reset state with a live request and slave ack
        drive(1'b1, 1'b0, 1'b1);
        chk_bus("reset", 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);

        @(negedge sys_clk);
        sys_rst = 1'b0;
        s0_cyc  = 1'b0;
        s0_stb  = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_rty   = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge sys_clk);
            s0_adr = tbl[i].a0;
            s1_adr = tbl[i].a1;
            drive(tbl[i].c0, tbl[i].c1, tbl[i].ack);
            chk_bus($sformatf("row%0d", i), tbl[i].e_gnt,
                    tbl[i].e_cyc, tbl[i].e_adr,
                    tbl[i].e_ack0, tbl[i].e_ack1);
        end

        // asynchronous reset in the middle of a port 0 burst
        s0_adr = 32'h500;
        s1_adr = 32'h600;
        drive(1'b1, 1'b1, 1'b0);
        chk("rst.pre_gnt", 64'(gnt), 64'(2'b00));
        drive(1'b1, 1'b1, 1'b1);
        chk_bus("rst.own0", 2'b01, 1'b1, 32'h500, 1'b1, 1'b0);
        sys_rst = 1'b1;
        #1;
        chk_bus("rst.async", 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        s0_cyc  = 1'b0;
        s0_stb  = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_rty   = 1'b0;
        #1;
        chk("rst.release_gnt", 64'(gnt), 64'(2'b00));
        drive(1'b0, 1'b1, 1'b0);
        chk_bus("rst.s1_gnt", 2'b10, 1'b1, 32'h600, 1'b0, 1'b0);

        // port 0 long burst while port 1 waits past MAX_WAIT
        drive(1'b1, 1'b0, 1'b0);
        chk("stv.s1_rel", 64'({gnt, m_cyc}), 64'({2'b10, 1'b0}));
        for (int b = 0; b < 18; b++) begin
            s0_cti = ((b % 9) == 8) ? CTI_EOB : CTI_INCR;
            drive(1'b1, 1'b1, 1'b1);
            chk($sformatf("stv.beat%0d", b),
                64'({gnt, m_cyc, m_cti, s0_ack, s1_ack}),
                64'({2'b01, 1'b1, s0_cti, 1'b1, 1'b0}));
        end
        s0_cti = CTI_CLASSIC;
        drive(1'b0, 1'b1, 1'b0);
        chk("stv.s0_fall", 64'({gnt, m_cyc}), 64'({2'b01, 1'b0}));
        drive(1'b1, 1'b1, 1'b0);
        chk_bus("stv.own1", 2'b10, 1'b1, 32'h600, 1'b0, 1'b0);

        // starve forces port 1 from IDLE over a port 0 request
        drive(1'b1, 1'b0, 1'b0);
        chk("idl.s1_rel", 64'(gnt), 64'(2'b10));
        for (int b = 0; b < 16; b++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk($sformatf("idl.wait%0d", b), 64'(gnt),
                64'(2'b01));
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("idl.drop", 64'(gnt), 64'(2'b01));
        drive(1'b1, 1'b1, 1'b0);
        chk("idl.both", 64'(gnt), 64'(2'b00));
        drive(1'b1, 1'b0, 1'b0);
        chk("idl.starve_gnt", 64'(gnt), 64'(2'b10));

        // one cycle short of MAX_WAIT: port 0 still wins
        for (int b = 0; b < 15; b++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk($sformatf("bnd.wait%0d", b), 64'(gnt),
                64'(2'b01));
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("bnd.drop", 64'(gnt), 64'(2'b01));
        drive(1'b1, 1'b1, 1'b0);
        chk("bnd.both", 64'(gnt), 64'(2'b00));
        drive(1'b1, 1'b0, 1'b0);
        chk("bnd.no_starve", 64'(gnt), 64'(2'b01));

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("end.idle", 64'({gnt, m_cyc}), 64'({2'b00, 1'b0}));
`ifdef ARB_STATS_EN
        chk("stat_gnt0", 64'(stat_gnt0), 64'd4);
        chk("stat_gnt1", 64'(stat_gnt1), 64'd3);
        chk("stat_starve", 64'(stat_starve), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
